flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface: takes the ALU's 3-bit flag vector {N,Z,V} and its per-bit write-enable mask, and holds the architectural flag register.
- Evaluates the 3-bit branch condition code for decode-stage branches and returns a registered taken/not-taken result.
- Same-cycle flag bypass is built in, and a wait FSM stalls branch resolution while a flag-writing instruction is still in flight.
- Sits between the EX-stage ALU and the fetch/PC-select logic.

Parameters:
BYPASS, 1, 1 = the same-cycle flag write is forwarded into branch evaluation; 0 = only the registered flags are used.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
flag_in  input  3  ALU flags: [2]=N, [1]=Z, [0]=V
flag_en  input  3  per-bit flag write enable, same bit mapping as flag_in
flag_wr_valid  input  1  ALU result with flags is retiring this cycle
flag_pending  input  1  a flag-writing instruction is in the pipe but not yet at the write port
stall  input  1  global pipeline stall
flush  input  1  kill the pending or in-progress branch
br_valid  input  1  branch in decode requests evaluation
br_cond  input  3  condition code
br_resolved  output  1  one-cycle pulse: branch result is valid
br_taken  output  1  branch outcome, meaningful only while br_resolved=1
br_wait  output  1  request to hold fetch/decode
flags_out  output  3  architectural flags {N,Z,V}

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset values: flags_q=3'b000, state=IDLE, cond_q=3'b000; br_resolved=0, br_taken=0, br_wait=0. Reset has priority over all other inputs, including mid-WAIT.
- write_fire = flag_wr_valid & ~stall.
  - On write_fire, each bit i with flag_en[i]=1 loads flag_in[i]; bits with flag_en[i]=0 hold.
  - Enable 3'b111 (add/sub) updates all flags; enable 3'b010 updates Z only; enable 3'b000 writes nothing even when flag_wr_valid=1.
- flags_out = flags_q (registered, no bypass).
- Effective flags eff[i] = (BYPASS & write_fire & flag_en[i]) ? flag_in[i] : flags_q[i].
- Condition evaluation on eff:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 unconditional: 1
- FSM states: IDLE and WAIT. When stall=1, state, cond_q and the flags all hold, and no resolve is issued.
- IDLE:
  - flush=1: stay in IDLE, no resolve (flush beats br_valid).
  - br_valid & ~flag_pending: resolve. Next cycle br_resolved=1 and br_taken=eval(br_cond, eff) as sampled this cycle. Latency is 1 cycle.
  - br_valid & flag_pending: latch cond_q=br_cond and go to WAIT.
- WAIT:
  - br_wait=1 (Moore output).
  - br_valid is ignored, because upstream is held.
  - flush=1: go to IDLE, no resolve.
  - flag_pending=0: resolve with cond_q and the current eff (bypass included), then go to IDLE.
  - flag_pending=1: stay in WAIT.
- br_wait = (state==WAIT) | (state==IDLE & br_valid & flag_pending & ~flush & ~stall). The combinational term closes the first-cycle gap.
- br_resolved is high for exactly one cycle per resolved branch. br_taken=0 whenever br_resolved=0.
- A simultaneous flag write and branch evaluation sees the new flags when BYPASS=1 and the old flags when BYPASS=0. The register updates in both cases.
- Back-to-back branches in IDLE with flag_pending=0 resolve on consecutive cycles.

Test Plan:
1. Reset, then write flag_in=3'b010, flag_en=3'b111, flag_wr_valid=1. Next cycle br_valid=1, br_cond=001 -> flags_out=3'b010, then br_resolved=1 and br_taken=1 one cycle later.
2. Flags 3'b000. Write flag_in=3'b111, flag_en=3'b010 -> flags_out=3'b010 (N and V held at 0). Then cond 011 -> taken=0; cond 110 -> taken=0.
3. Bypass: flags_q=3'b000. In the same cycle, write flag_in=3'b100 with en=3'b111 and br_valid with cond=011 -> BYPASS=1 gives taken=1; BYPASS=0 gives taken=0. flags_out=3'b100 in both cases.
4. Wait path: br_valid, cond=000, flag_pending=1 for 3 cycles. On the 3rd cycle write Z=1 with flag_pending=0 -> br_wait high for cycles 0-3, br_resolved pulses once on cycle 4 with taken=0.
5. Flush in WAIT: enter WAIT, assert flush -> state IDLE, br_wait=0, no br_resolved pulse. Same with rst mid-WAIT -> all outputs 0 and flags_out=3'b000.
6. Stall: assert stall during a flag write and a branch request -> flags unchanged and no resolve. Deassert stall -> the request is processed normally the next cycle.

Source files
------------

// File: rtl/flag_branch_if.sv
// Flag write and branch request/response bundle between the EX-stage ALU,
// decode and the flag/branch unit.
interface flag_branch_if;
  logic [2:0] flag_in;
  logic [2:0] flag_en;
  logic       flag_wr_valid;
  logic       flag_pending;
  logic       stall;
  logic       flush;
  logic       br_valid;
  logic [2:0] br_cond;
  logic       br_resolved;
  logic       br_taken;
  logic       br_wait;
  logic [2:0] flags_out;

  modport master (
    output flag_in, flag_en, flag_wr_valid, flag_pending, stall, flush,
           br_valid, br_cond,
    input  br_resolved, br_taken, br_wait, flags_out
  );

  modport slave (
    input  flag_in, flag_en, flag_wr_valid, flag_pending, stall, flush,
           br_valid, br_cond,
    output br_resolved, br_taken, br_wait, flags_out
  );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural {N,Z,V} flag register with branch condition evaluation.
// Branches resolve one cycle after acceptance; a branch that arrives while a
// flag-writing instruction is still in flight parks in WAIT until it lands.
module flag_branch_unit #(
  parameter bit BYPASS = 1'b1
) (
  input logic         clk,
  input logic         rst,
  flag_branch_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] cond_q, cond_d;
  logic [2:0] flags_q;
  logic [2:0] eff;
  logic [2:0] res_cond;
  logic       write_fire;
  logic       resolve_now;
  logic       taken_now;
  logic       br_resolved_p1;
  logic       br_taken_p1;

  // Condition code decode on a {N,Z,V} vector.
  function automatic logic eval_cond(input logic [2:0] cc, input logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (cc)
      3'b000:  eval_cond = ~z;
      3'b001:  eval_cond = z;
      3'b010:  eval_cond = ~z & ~n;
      3'b011:  eval_cond = n;
      3'b100:  eval_cond = z | (~z & ~n);
      3'b101:  eval_cond = n | z;
      3'b110:  eval_cond = v;
      default: eval_cond = 1'b1;
    endcase
  endfunction

  assign write_fire = bus.flag_wr_valid & ~bus.stall;

  // Effective flags: optionally forward this cycle's write, bit by bit.
  always_comb begin
    eff = flags_q;
    for (int i = 0; i < 3; i++) begin
      if (BYPASS && write_fire && bus.flag_en[i]) eff[i] = bus.flag_in[i];
    end
  end

  // Next-state and resolve decision; stall freezes everything.
  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    resolve_now = 1'b0;
    res_cond    = cond_q;
    if (!bus.stall) begin
      case (state_q)
        S_IDLE: begin
          if (!bus.flush && bus.br_valid) begin
            if (!bus.flag_pending) begin
              resolve_now = 1'b1;
              res_cond    = bus.br_cond;
            end else begin
              state_d = S_WAIT;
              cond_d  = bus.br_cond;
            end
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            state_d = S_IDLE;
          end else if (!bus.flag_pending) begin
            resolve_now = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign taken_now = resolve_now & eval_cond(res_cond, eff);

  // FSM state and parked condition code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cond_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
    end
  end

  // Architectural flags with per-bit write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (write_fire) begin
      flags_q <= (flags_q & ~bus.flag_en) | (bus.flag_in & bus.flag_en);
    end
  end

  // Stage 1: registered resolve pulse and outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_resolved_p1 <= 1'b0;
      br_taken_p1    <= 1'b0;
    end else begin
      br_resolved_p1 <= resolve_now;
      br_taken_p1    <= taken_now;
    end
  end

  assign bus.br_resolved = br_resolved_p1;
  assign bus.br_taken    = br_taken_p1;
  assign bus.flags_out   = flags_q;
  assign bus.br_wait     = (state_q == S_WAIT) |
                           ((state_q == S_IDLE) & bus.br_valid & bus.flag_pending &
                            ~bus.flush & ~bus.stall);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: one BYPASS=1 and one BYPASS=0 instance share
// stimulus; a reference model predicts flags, wait and branch outcomes, and
// a monitor consumes predicted outcomes as resolve pulses appear.
module tb_flag_branch_unit;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flag_branch_if bus1 ();
  flag_branch_if bus0 ();

  flag_branch_unit #(.BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  flag_branch_unit #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct packed {
    logic t1;
    logic t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   checking = 1'b0;

  // Reference model state
  logic [2:0] m_flags;
  bit         m_waiting;
  logic [2:0] m_cond;

  function automatic logic ref_taken(input logic [2:0] cc, input logic [2:0] f);
    bit n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] fi, input logic [2:0] fe,
                     input logic wv, input logic fp, input logic st, input logic fl,
                     input logic bv, input logic [2:0] bc);
    logic [2:0] new_f, c;
    bit res, exp_wait;
    @(negedge clk);
    rst = r;
    bus1.flag_in = fi;  bus0.flag_in = fi;
    bus1.flag_en = fe;  bus0.flag_en = fe;
    bus1.flag_wr_valid = wv; bus0.flag_wr_valid = wv;
    bus1.flag_pending = fp;  bus0.flag_pending = fp;
    bus1.stall = st;    bus0.stall = st;
    bus1.flush = fl;    bus0.flush = fl;
    bus1.br_valid = bv; bus0.br_valid = bv;
    bus1.br_cond = bc;  bus0.br_cond = bc;
    #1;
    if (checking) begin
      exp_wait = m_waiting || (bv && fp && !fl && !st);
      chk("br_wait_byp1", {2'b00, bus1.br_wait}, {2'b00, exp_wait});
      chk("br_wait_byp0", {2'b00, bus0.br_wait}, {2'b00, exp_wait});
      chk("flags_out_byp1", bus1.flags_out, m_flags);
      chk("flags_out_byp0", bus0.flags_out, m_flags);
    end
    if (r) begin
      m_flags = 3'b000;
      m_waiting = 1'b0;
      m_cond = 3'b000;
      checking = 1'b1;
    end else if (!st) begin
      new_f = m_flags;
      if (wv) begin
        for (int i = 0; i < 3; i++) if (fe[i]) new_f[i] = fi[i];
      end
      res = 1'b0;
      c = 3'b000;
      if (!m_waiting) begin
        if (!fl && bv) begin
          if (!fp) begin res = 1'b1; c = bc; end
          else begin m_waiting = 1'b1; m_cond = bc; end
        end
      end else if (fl) begin
        m_waiting = 1'b0;
      end else if (!fp) begin
        res = 1'b1; c = m_cond; m_waiting = 1'b0;
      end
      if (res) exp_q.push_back('{t1: ref_taken(c, new_f), t0: ref_taken(c, m_flags)});
      m_flags = new_f;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000);
  endtask

  // Monitor: every resolve pulse must consume exactly the outcome predicted
  // for the preceding cycle; taken must be low when no pulse is present.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (checking) begin
      if (bus1.br_resolved !== bus0.br_resolved) begin
        n_cmp++; n_err++;
        $display("FAIL resolve_align: byp1=%b byp0=%b", bus1.br_resolved, bus0.br_resolved);
      end
      if (bus1.br_resolved === 1'b1 || bus0.br_resolved === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_resolve: got 1, expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          n_cmp--;
          chk("br_taken_byp1", {2'b00, bus1.br_taken}, {2'b00, e.t1});
          chk("br_taken_byp0", {2'b00, bus0.br_taken}, {2'b00, e.t0});
        end
      end else begin
        if (exp_q.size() != 0) begin
          n_cmp++; n_err++;
          void'(exp_q.pop_front());
          $display("FAIL missing_resolve: got br_resolved=%b, expected 1 at %0t",
                   bus1.br_resolved, $time);
        end
        chk("taken_idle_byp1", {2'b00, bus1.br_taken}, 3'b000);
        chk("taken_idle_byp0", {2'b00, bus0.br_taken}, 3'b000);
      end
    end
  end

  initial begin
    rst = 1'b1;
    cyc(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000);
    cyc(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000);
    idle(1);
    // Full write then EQ branch
    cyc(0, 3'b010, 3'b111, 1, 0, 0, 0, 0, 3'b000);
    cyc(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 3'b001);
    idle(2);
    // Z-only write, then LT and OV
    cyc(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000);
    cyc(0, 3'b111, 3'b010, 1, 0, 0, 0, 0, 3'b000);
    cyc(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 3'b011);
    cyc(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 3'b110);
    // Enable 000 writes nothing
    cyc(0, 3'b111, 3'b000, 1, 0, 0, 0, 0, 3'b000);
    idle(1);
    // Same-cycle write and branch (bypass difference)
    cyc(1, 3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000);
    cyc(0, 3'b100, 3'b111, 1, 0, 0, 0, 1, 3'b011);
    idle(2);
    // Wait path: pending for three cycles, then Z written as pending drops
    cyc(0, 3'b000, 3'b111, 1, 0, 0, 0, 0, 3'b000);
    cyc(0, 3'b000, 3'b000, 0, 1, 0, 0, 1, 3'b000);
    cyc(0, 3'b000, 3'b000, 0, 1, 0, 0, 1, 3'b000);
    cyc(0, 3'b000, 3'b000, 0, 1, 0, 0, 1, 3'b000);
    cyc(0, 3'b010, 3'b010, 1, 0, 0, 0, 1, 3'b000);
    idle(2);
    // Flush in WAIT
    cyc(0, 3'b000, 3'b000, 0, 1, 0, 0, 1, 3'b111);
    cyc(0, 3'b000, 3'b000, 0, 1, 0, 1, 0, 3'b000);
    idle(2);
    // Reset mid-WAIT after a flag write
    cyc(0, 3'b101, 3'b111, 1, 0, 0, 0, 0, 3'b000);
    cyc(0, 3'b000, 3'b000, 0, 1, 0, 0, 1, 3'b111);
    cyc(0, 3'b000, 3'b000, 0, 1, 0, 0, 0, 3'b000);
    cyc(1, 3'b000, 3'b000, 0, 1, 0, 0, 0, 3'b000);
    idle(2);
    // Stall during write and branch, then release
    cyc(0, 3'b010, 3'b111, 1, 0, 1, 0, 1, 3'b001);
    cyc(0, 3'b010, 3'b111, 1, 0, 0, 0, 1, 3'b001);
    // Back-to-back branches
    cyc(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 3'b000);
    cyc(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 3'b100);
    cyc(0, 3'b000, 3'b000, 0, 0, 0, 0, 1, 3'b101);
    idle(2);
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 99) == 0),
          3'($urandom), 3'($urandom),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 1) == 0),
          3'($urandom));
    end
    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
